// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Purpose  : Miss-handling controller for a direct-mapped cache set array.
//            Handles lookup, dirty writeback, refill and fill over Avalon-MM.
// Revision : 1.0
// ============================================================================
module cache_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [DATA_WIDTH-1:0] core_address,
    output logic                  core_waitrequest,

    output logic                  set_read,
    output logic                  set_write,
    input  logic                  set_hit,
    input  logic                  set_valid,
    input  logic                  set_dirty,
    input  logic [DATA_WIDTH-1:0] set_dirty_data,
    input  logic [DATA_WIDTH-1:0] set_victim_address,

    output logic                  fill,
    output logic [DATA_WIDTH-1:0] fill_address,
    output logic [DATA_WIDTH-1:0] fill_data,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    input  logic                  mem_readdatavalid,
    input  logic [DATA_WIDTH-1:0] mem_readdata,

    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        REFILL = 3'd3,
        RWAIT  = 3'd4,
        REREAD = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] victim_addr;
    logic [DATA_WIDTH-1:0] victim_data;
    logic [DATA_WIDTH-1:0] miss_addr;
    logic                  retry_flag;

    logic                  core_req;
    logic                  lookup_hit;
    logic                  lookup_miss;
    logic                  wb_done;
    logic                  unused_addr_bits;

    assign core_req         = core_read | core_write;
    assign lookup_hit       = (state == LOOKUP) &&  set_hit;
    assign lookup_miss      = (state == LOOKUP) && !set_hit;
    assign wb_done          = (state == WB) && !mem_waitrequest;
    assign unused_addr_bits = ^core_address[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            retry_flag <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            state <= state_next;

            // Retry marks the post-fill lookup so its hit is not double counted
            if (state == REREAD)
                retry_flag <= 1'b1;
            else if (state_next == IDLE)
                retry_flag <= 1'b0;

            if (lookup_hit && !retry_flag)
                hit_count <= hit_count + CNT_ONE;
            if (lookup_miss)
                miss_count <= miss_count + CNT_ONE;
            if (wb_done)
                wb_count <= wb_count + CNT_ONE;
        end
    end

    // Victim and miss line are captured once per miss and held for the bus
    always_ff @(posedge clk) begin
        if (lookup_miss) begin
            victim_addr <= set_victim_address;
            victim_data <= set_dirty_data;
            miss_addr   <= {core_address[DATA_WIDTH-1:2], 2'b00};
        end
    end

    always_comb begin
        state_next       = state;
        core_waitrequest = 1'b1;
        set_read         = 1'b0;
        set_write        = 1'b0;
        fill             = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;

        case (state)
            IDLE: begin
                if (core_req) begin
                    set_read   = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (set_hit) begin
                    core_waitrequest = 1'b0;
                    set_write        = core_write;
                    state_next       = IDLE;
                end else if (set_valid && set_dirty) begin
                    state_next = WB;
                end else begin
                    state_next = REFILL;
                end
            end
            WB: begin
                mem_write = 1'b1;
                if (!mem_waitrequest)
                    state_next = REFILL;
            end
            REFILL: begin
                mem_read = 1'b1;
                if (!mem_waitrequest)
                    state_next = RWAIT;
            end
            RWAIT: begin
                if (mem_readdatavalid) begin
                    fill       = 1'b1;
                    state_next = REREAD;
                end
            end
            REREAD: begin
                set_read   = 1'b1;
                state_next = LOOKUP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_address   = (state == WB) ? victim_addr : miss_addr;
    assign mem_writedata = victim_data;
    assign fill_address  = miss_addr;
    assign fill_data     = mem_readdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Purpose  : Directed bench for cache_ctrl with array/memory models and a
//            scoreboard queue of expected bus commands and fills.
// Revision : 1.0
// ============================================================================
module tb_cache_ctrl;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_read, core_write, core_waitrequest;
    logic [DW-1:0] core_address;
    logic          set_read, set_write, set_hit, set_valid, set_dirty;
    logic [DW-1:0] set_dirty_data, set_victim_address;
    logic          fill;
    logic [DW-1:0] fill_address, fill_data;
    logic          mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
    logic [DW-1:0] mem_address, mem_writedata, mem_readdata;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    cache_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .core_read(core_read), .core_write(core_write),
        .core_address(core_address), .core_waitrequest(core_waitrequest),
        .set_read(set_read), .set_write(set_write), .set_hit(set_hit),
        .set_valid(set_valid), .set_dirty(set_dirty),
        .set_dirty_data(set_dirty_data), .set_victim_address(set_victim_address),
        .fill(fill), .fill_address(fill_address), .fill_data(fill_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    // Set array model: 32 sets, tag = addr[31:7], index = addr[6:2]
    logic          arr_valid [32];
    logic          arr_dirty [32];
    logic [24:0]   arr_tag   [32];
    logic [31:0]   arr_data  [32];
    logic [31:0]   mem_model [logic [31:0]];

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 fill
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    logic        lookup_pend = 1'b0;
    logic [31:0] lookup_addr = '0;
    int          stall_cfg = 0, stall_left = 0, resp_cnt = 0;
    logic [31:0] resp_addr = '0;
    bit          drop_fill = 1'b0;
    int          fill_seen = 0, sw_seen = 0;
    bit          completed = 1'b0;
    logic        last_fill = 1'b0, last_wait = 1'b1, last_mread = 1'b0;
    logic [31:0] wdata_core = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Drive the environment-owned DUT inputs for the current cycle
    task automatic env_drive();
        logic [4:0] li;
        li = lookup_addr[6:2];
        if (lookup_pend) begin
            set_hit            = arr_valid[li] && (arr_tag[li] == lookup_addr[31:7]);
            set_valid          = arr_valid[li];
            set_dirty          = arr_dirty[li];
            set_dirty_data     = arr_data[li];
            set_victim_address = {arr_tag[li], li, 2'b00};
        end else begin
            set_hit = 1'b0; set_valid = 1'b0; set_dirty = 1'b0;
            set_dirty_data = '0; set_victim_address = '0;
        end
        mem_waitrequest   = (stall_left > 0);
        mem_readdatavalid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = mem_model.exists(resp_addr) ? mem_model[resp_addr] : 32'h0;
            end
        end
    endtask

    // Observe outputs for this cycle and update models as of the coming edge
    task automatic monitor();
        logic [4:0] fi;
        completed  = !core_waitrequest;
        last_fill  = fill;
        last_wait  = core_waitrequest;
        last_mread = mem_read;
        if (mem_read || mem_write) begin
            check("mem_rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_mem_cmd", {30'b0, mem_write, mem_read}, 32'd0);
            end else begin
                check("mem_cmd_kind", mem_write ? 0 : 1, exp_q[0].kind);
                check("mem_address", mem_address, exp_q[0].addr);
                if (mem_write) check("mem_writedata", mem_writedata, exp_q[0].data);
            end
            if (!mem_waitrequest) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (mem_write) mem_model[mem_address] = mem_writedata;
                else begin resp_cnt = 2; resp_addr = mem_address; end
                stall_left = stall_cfg;
            end else begin
                stall_left--;
            end
        end
        if (fill) begin
            fill_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_fill", {31'b0, fill}, 32'd0);
            end else begin
                check("fill_kind", 2, exp_q[0].kind);
                check("fill_address", fill_address, exp_q[0].addr);
                check("fill_data", fill_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            fi = fill_address[6:2];
            if (drop_fill) drop_fill = 1'b0;
            else begin
                arr_valid[fi] = 1'b1; arr_dirty[fi] = 1'b0;
                arr_tag[fi] = fill_address[31:7]; arr_data[fi] = fill_data;
            end
        end
        if (set_write) begin
            sw_seen++;
            fi = core_address[6:2];
            arr_data[fi] = wdata_core; arr_dirty[fi] = 1'b1;
        end
        lookup_pend = set_read;
        lookup_addr = core_address;
    endtask

    task automatic cycle();
        env_drive();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        core_read = !wr; core_write = wr; core_address = addr; wdata_core = wd;
        for (int k = 0; k < 80 && !done; k++) begin
            cycle();
            if (completed) begin lat = k; done = 1'b1; end
        end
        core_read = 1'b0; core_write = 1'b0;
    endtask

    task automatic idle_cycle();
        cycle();
        check("idle_waitrequest", {31'b0, last_wait}, 32'd1);
    endtask

    task automatic check_counters(input string tag, input int h, input int m, input int w);
        check({tag, "_hit_count"}, hit_count, h);
        check({tag, "_miss_count"}, miss_count, m);
        check({tag, "_wb_count"}, wb_count, w);
    endtask

    int lat;
    int n;

    initial begin
        for (int i = 0; i < 32; i++) begin
            arr_valid[i] = 1'b0; arr_dirty[i] = 1'b0; arr_tag[i] = '0; arr_data[i] = '0;
        end
        // Lines 0x200..0x21C already resident in sets 0..7
        for (int i = 0; i < 8; i++) begin
            arr_valid[i] = 1'b1; arr_tag[i] = 25'd4; arr_data[i] = 32'h5000_0000 + i;
        end
        mem_model[32'h40]  = 32'hDEAD_BEEF;
        mem_model[32'hC0]  = 32'hCAFE_00C0;
        mem_model[32'h140] = 32'h0BAD_0140;
        mem_model[32'h1C0] = 32'h0000_01C0;
        mem_model[32'h240] = 32'h0240_F00D;
        core_read = 1'b0; core_write = 1'b0; core_address = '0;
        mem_readdata = '0;
        rst = 1'b1;
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        // Reset state
        env_drive();
        #1;
        check("rst_core_waitrequest", {31'b0, core_waitrequest}, 32'd1);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_fill", {31'b0, fill}, 32'd0);
        check("rst_set_write", {31'b0, set_write}, 32'd0);
        check_counters("rst", 0, 0, 0);
        @(negedge clk);

        // Cold read miss
        push_exp(1, 32'h40, 32'h0);
        push_exp(2, 32'h40, 32'hDEAD_BEEF);
        access(1'b0, 32'h40, 32'h0, lat);
        check("cold_latency", lat, 6);
        idle_cycle();
        check_counters("cold", 0, 1, 0);

        // Repeat read hits
        access(1'b0, 32'h40, 32'h0, lat);
        check("hit_latency", lat, 1);
        idle_cycle();
        check_counters("hit", 1, 1, 0);

        // Write hit then dirty-victim miss in the same set
        access(1'b1, 32'h40, 32'h1234_5678, lat);
        check("write_hit_latency", lat, 1);
        check("write_hit_set_write", sw_seen, 1);
        push_exp(0, 32'h40, 32'h1234_5678);
        push_exp(1, 32'hC0, 32'h0);
        push_exp(2, 32'hC0, 32'hCAFE_00C0);
        access(1'b0, 32'hC0, 32'h0, lat);
        check("dirty_latency", lat, 7);
        idle_cycle();
        check_counters("dirty", 2, 2, 1);

        // Writeback and refill under 5-cycle waitrequest
        access(1'b1, 32'hC0, 32'hA5A5_0001, lat);
        check("write_hit2_latency", lat, 1);
        stall_cfg = 5; stall_left = 5;
        push_exp(0, 32'hC0, 32'hA5A5_0001);
        push_exp(1, 32'h140, 32'h0);
        push_exp(2, 32'h140, 32'h0BAD_0140);
        access(1'b0, 32'h140, 32'h0, lat);
        stall_cfg = 0; stall_left = 0;
        check("stall_latency", lat, 17);
        idle_cycle();
        check_counters("stall", 3, 3, 2);
        check("stall_fill_total", fill_seen, 3);

        // Reset during RWAIT; late response must be ignored
        push_exp(1, 32'h1C0, 32'h0);
        core_read = 1'b1; core_address = 32'h1C0;
        cycle();
        cycle();
        cycle();
        core_read = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("rwait_rst_fill", {31'b0, last_fill}, 32'd0);
        check("rwait_rst_waitrequest", {31'b0, last_wait}, 32'd1);
        check("rwait_rst_mem_read", {31'b0, last_mread}, 32'd0);
        check_counters("rwait_rst", 0, 0, 0);
        idle_cycle();

        // Back-to-back hits to 8 resident lines
        n = 0;
        core_read = 1'b1; core_address = 32'h200;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (completed) begin
                n++;
                core_address = 32'h200 + 32'(4 * n);
            end
        end
        core_read = 1'b0;
        check("b2b_completions", n, 8);
        idle_cycle();
        check_counters("b2b", 8, 0, 0);

        // Retry lookup misses once (fill lost) and recovers via a second refill
        drop_fill = 1'b1;
        push_exp(1, 32'h240, 32'h0);
        push_exp(2, 32'h240, 32'h0240_F00D);
        push_exp(1, 32'h240, 32'h0);
        push_exp(2, 32'h240, 32'h0240_F00D);
        access(1'b0, 32'h240, 32'h0, lat);
        check("retry_miss_latency", lat, 11);
        idle_cycle();
        check_counters("retry", 8, 2, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        check("total_fills", fill_seen, 5);
        check("total_set_writes", sw_seen, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
